// File: rtl/uart_rx_deserializer.sv
// UART receiver: 2-flop synchronizer, centre sampling, LSB-first deserialization into a one-entry output register.
// Latency: pin falling edge to rx_valid = 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 clocks (+/-1 edge phase).
// Backpressure: a byte completing while rx_valid && !rx_ready is dropped and overrun pulses; the held byte is kept.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  // Baud counter counts down to zero; the reload value sets the distance to the next sample.
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t               state_q, state_n;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic [IW-1:0]        bit_q, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n;
  logic                 fe_n;
  logic                 ov_n;
  logic                 rx_m;
  logic                 rx_s;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // State, counters, shift register and the registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      bit_q         <= bit_n;
      shift_q       <= shift_n;
      rx_data       <= data_n;
      rx_valid      <= valid_n;
      framing_error <= fe_n;
      overrun       <= ov_n;
    end
  end

  // Next-state logic: frame sequencing plus the output handshake.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    data_n  = rx_data;
    // A handshake this cycle empties the holding register unless a new byte lands.
    valid_n = rx_valid && !rx_ready;
    fe_n    = 1'b0;
    ov_n    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_n   = HALF_M1;
          state_n = S_START;
        end
      end

      S_START: begin
        if (cnt_q == '0) begin
          if (!rx_s) begin
            cnt_n   = BIT_M1;
            bit_n   = '0;
            state_n = S_DATA;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == '0) begin
          shift_n = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_n   = BIT_M1;
          if (bit_q == LAST_BIT) begin
            state_n = S_STOP;
          end else begin
            bit_n = bit_q + IW'(1);
          end
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            // Returning to IDLE at mid-stop keeps back-to-back start bits catchable.
            state_n = S_IDLE;
            if (!valid_n) begin
              data_n  = shift_q;
              valid_n = 1'b1;
            end else begin
              ov_n = 1'b1;
            end
          end else begin
            fe_n    = 1'b1;
            state_n = S_WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end

      S_WAIT_IDLE: begin
        if (rx_s) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Testbench for uart_rx_deserializer with CLKS_PER_BIT=4, DATA_BITS=8.
// Frame-level model predicts the stop-sample edge of each frame and the resulting outputs.
// Outputs compared every cycle on the falling edge; directed checks pin the model.
module tb_uart_rx_deserializer;

  localparam int N    = 4;
  localparam int D    = 8;
  localparam int HALF = N / 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx;
  logic [D-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         framing_error;
  logic         overrun;
  logic         busy;

  int checks = 0;
  int errors = 0;

  uart_rx_deserializer #(.CLKS_PER_BIT(N), .DATA_BITS(D)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Model state
  int           cyc = 0;
  bit           started = 1'b0;
  bit           m_valid = 1'b0;
  logic [D-1:0] m_data = '0;
  bit           m_fe = 1'b0;
  bit           m_ov = 1'b0;
  bit           nv;
  int           ev_e[$];
  logic [D-1:0] ev_b[$];
  bit           ev_s[$];

  // Observations
  logic [D-1:0] got[$];
  int           fe_cnt = 0;
  int           ov_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update at each active edge, using inputs as sampled by that edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      started = 1'b1;
      m_valid = 1'b0;
      m_data  = '0;
      m_fe    = 1'b0;
      m_ov    = 1'b0;
      ev_e.delete();
      ev_b.delete();
      ev_s.delete();
    end else begin
      nv   = m_valid && !rx_ready;
      m_fe = 1'b0;
      m_ov = 1'b0;
      if (ev_e.size() > 0 && ev_e[0] == cyc) begin
        if (ev_s[0]) begin
          if (!nv) begin
            nv     = 1'b1;
            m_data = ev_b[0];
          end else begin
            m_ov = 1'b1;
          end
        end else begin
          m_fe = 1'b1;
        end
        void'(ev_e.pop_front());
        void'(ev_b.pop_front());
        void'(ev_s.pop_front());
      end
      m_valid = nv;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
      chk("rx_data", {24'd0, rx_data}, {24'd0, m_data});
      chk("framing_error", {31'd0, framing_error}, {31'd0, m_fe});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ov});
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    step(N);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    step(n * N);
  endtask

  // Drive one frame; predicts the stop-sample edge from the pin falling edge.
  task automatic send_frame(input logic [D-1:0] b, input logic stop_bit);
    ev_e.push_back(cyc + 1 + 2 + HALF + (D + 1) * N);
    ev_b.push_back(b);
    ev_s.push_back(stop_bit);
    bit_out(1'b0);
    for (int i = 0; i < D; i++) bit_out(b[i]);
    bit_out(stop_bit);
  endtask

  initial begin
    rx       = 1'b1;
    rst_n    = 1'b0;
    rx_ready = 1'b1;
    step(3);
    chk("reset rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset framing_error", {31'd0, framing_error}, 32'd0);
    chk("reset overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    idle_bits(2);

    // Single byte
    send_frame(8'hA5, 1'b1);
    idle_bits(2);
    chk("a5 count", got.size(), 32'd1);
    chk("a5 byte", {24'd0, got[0]}, 32'hA5);
    chk("a5 busy", {31'd0, busy}, 32'd0);
    chk("a5 errors", fe_cnt + ov_cnt, 32'd0);

    // Back-to-back frames
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle_bits(3);
    chk("b2b count", got.size(), 32'd3);
    chk("b2b first", {24'd0, got[1]}, 32'h3C);
    chk("b2b second", {24'd0, got[2]}, 32'hC3);

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle_bits(1);
    send_frame(8'h22, 1'b1);
    idle_bits(3);
    chk("ovr held valid", {31'd0, rx_valid}, 32'd1);
    chk("ovr held data", {24'd0, rx_data}, 32'h11);
    chk("ovr pulses", ov_cnt, 32'd1);
    rx_ready = 1'b1;
    step(2);
    chk("ovr drain count", got.size(), 32'd4);
    chk("ovr drain byte", {24'd0, got[3]}, 32'h11);
    chk("ovr drain valid", {31'd0, rx_valid}, 32'd0);

    // Framing error, line held low, then recovery
    send_frame(8'h55, 1'b0);
    bit_out(1'b0);
    chk("fe wait busy", {31'd0, busy}, 32'd1);
    bit_out(1'b0);
    bit_out(1'b0);
    idle_bits(3);
    chk("fe busy after", {31'd0, busy}, 32'd0);
    send_frame(8'h0F, 1'b1);
    idle_bits(3);
    chk("fe pulses", fe_cnt, 32'd1);
    chk("fe recovery count", got.size(), 32'd5);
    chk("fe recovery byte", {24'd0, got[4]}, 32'h0F);

    // One-clock glitch while idle
    rx = 1'b0;
    step(1);
    rx = 1'b1;
    step(3 * N);
    chk("glitch count", got.size(), 32'd5);
    chk("glitch fe", fe_cnt, 32'd1);
    chk("glitch busy", {31'd0, busy}, 32'd0);

    // Reset during the 4th data bit
    fork
      send_frame(8'hFF, 1'b1);
      begin
        step(4 * N + 2);
        rst_n = 1'b0;
        step(1);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst valid", {31'd0, rx_valid}, 32'd0);
        rst_n = 1'b1;
      end
    join
    idle_bits(2);
    send_frame(8'h81, 1'b1);
    idle_bits(3);
    chk("midrst count", got.size(), 32'd6);
    chk("midrst byte", {24'd0, got[5]}, 32'h81);
    chk("model last byte", {24'd0, m_data}, 32'h81);
    chk("final fe", fe_cnt, 32'd1);
    chk("final ov", ov_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
